// File: rtl/img_ddr_arbiter_pkg.sv
// Shared definitions for the image DDR port arbiter: FSM state encoding,
// requester ids and default widths.
package img_ddr_arbiter_pkg;

    localparam int ADDR_W_DEF  = 19;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 1023;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_e;

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_UART = 1'b1;

endpackage

// File: rtl/img_ddr_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. The pointer only flips when both sides were
// pending at the moment a grant is taken.
module rr_arbiter2
    import img_ddr_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_id
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and pointer update
    always_comb begin
        gnt_id = REQ_CPU;
        ptr_d  = ptr_q;
        if (req[0] && req[1]) begin
            gnt_id = ptr_q;
            if (take) begin
                ptr_d = ~ptr_q;
            end else begin
                ptr_d = ptr_q;
            end
        end else if (req[1]) begin
            gnt_id = REQ_UART;
        end else begin
            gnt_id = REQ_CPU;
        end
    end

    // Pointer register, starts favouring the CPU
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ_CPU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/img_ddr_arbiter.sv
// Shares the image DDR CPU-side port between the core and the UART loader,
// with a guaranteed strobe-low cycle between accesses and an access timeout.
module img_ddr_arbiter
    import img_ddr_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr_rd,
    input  logic [ADDR_W-1:0] cpu_addr_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              uart_re,
    input  logic              uart_we,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    output logic [DATA_W-1:0] uart_rdata,
    output logic              uart_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready_re,
    input  logic              mem_ready_we,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              side_q, side_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] uart_rdata_q, uart_rdata_d;
    logic              cpu_done_q, cpu_done_d;
    logic              uart_done_q, uart_done_d;
    logic              timeout_err_q, timeout_err_d;

    logic [1:0] req;
    logic       take;
    logic       gnt_id;
    logic       ready_hit;

    assign req       = {uart_re | uart_we, cpu_re | cpu_we};
    assign take      = (state_q == IDLE) && (req != 2'b00);
    assign ready_hit = op_we_q ? mem_ready_we : mem_ready_re;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .take   (take),
        .gnt_id (gnt_id)
    );

    // Access sequencing: grant, wait for the matching ready or timeout, recover
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        side_d        = side_q;
        op_we_d       = op_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_re_d      = mem_re_q;
        mem_we_d      = mem_we_q;
        cpu_rdata_d   = cpu_rdata_q;
        uart_rdata_d  = uart_rdata_q;
        cpu_done_d    = 1'b0;
        uart_done_d   = 1'b0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    side_d = gnt_id;
                    cnt_d  = '0;
                    if (gnt_id == REQ_UART) begin
                        op_we_d     = uart_we;
                        mem_addr_d  = uart_addr;
                        mem_wdata_d = uart_wdata;
                        mem_re_d    = ~uart_we;
                        mem_we_d    = uart_we;
                    end else begin
                        op_we_d     = cpu_we;
                        mem_addr_d  = cpu_we ? cpu_addr_wr : cpu_addr_rd;
                        mem_wdata_d = cpu_wdata;
                        mem_re_d    = ~cpu_we;
                        mem_we_d    = cpu_we;
                    end
                    state_d = ACCESS;
                end else begin
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                end
            end
            ACCESS: begin
                // A ready in the last allowed cycle still counts as success
                if (ready_hit || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    mem_re_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    cpu_done_d  = (side_q == REQ_CPU);
                    uart_done_d = (side_q == REQ_UART);
                    state_d     = RECOVER;
                    if (ready_hit) begin
                        if (!op_we_q && (side_q == REQ_CPU)) begin
                            cpu_rdata_d = mem_rdata;
                        end else if (!op_we_q) begin
                            uart_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = cpu_rdata_q;
                        end
                    end else begin
                        timeout_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            side_q        <= REQ_CPU;
            op_we_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            cpu_rdata_q   <= '0;
            uart_rdata_q  <= '0;
            cpu_done_q    <= 1'b0;
            uart_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            side_q        <= side_d;
            op_we_q       <= op_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_re_q      <= mem_re_d;
            mem_we_q      <= mem_we_d;
            cpu_rdata_q   <= cpu_rdata_d;
            uart_rdata_q  <= uart_rdata_d;
            cpu_done_q    <= cpu_done_d;
            uart_done_q   <= uart_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_done    = cpu_done_q;
    assign uart_rdata  = uart_rdata_q;
    assign uart_done   = uart_done_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_img_ddr_arbiter.sv
// Self-checking bench for img_ddr_arbiter: directed vector table, hand-written
// timeout/reset sequences and randomized traffic against a transaction-level model.
module tb_img_ddr_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_re, cpu_we, uart_re, uart_we;
    logic [AW-1:0] cpu_addr_rd, cpu_addr_wr, uart_addr;
    logic [DW-1:0] cpu_wdata, uart_wdata;
    logic [DW-1:0] cpu_rdata, uart_rdata;
    logic          cpu_done, uart_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_re, mem_we, mem_ready_re, mem_ready_we;
    logic          timeout_err;

    int checks = 0;
    int failures = 0;

    // Model of the architecturally visible state
    logic          ptr_m;
    logic [DW-1:0] cpu_rd_m, uart_rd_m;
    logic          terr_m;

    img_ddr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr_rd(cpu_addr_rd),
        .cpu_addr_wr(cpu_addr_wr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .uart_re(uart_re), .uart_we(uart_we), .uart_addr(uart_addr),
        .uart_wdata(uart_wdata), .uart_rdata(uart_rdata), .uart_done(uart_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ready_re(mem_ready_re), .mem_ready_we(mem_ready_we),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          c_re, c_we;
        logic [AW-1:0] c_ard, c_awr;
        logic [DW-1:0] c_wd;
        logic          u_re, u_we;
        logic [AW-1:0] u_a;
        logic [DW-1:0] u_wd;
        int            lat;
        logic [DW-1:0] rv;
        logic          noise;
        logic          e1_side, e1_we;
        logic [AW-1:0] e1_addr;
        logic [DW-1:0] e1_wd;
        logic          e2_v, e2_side, e2_we;
        logic [AW-1:0] e2_addr;
        logic [DW-1:0] e2_wd;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One complete access: strobe checks, ready after lat strobe cycles, done, recover
    task automatic run_acc(input logic side, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int lat, input logic [DW-1:0] rv,
                           input logic noise);
        step();
        chk("grant_re", mem_re, !we);
        chk("grant_we", mem_we, we);
        chk("grant_addr", mem_addr, addr);
        if (we) chk("grant_wdata", mem_wdata, wd);
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin
                step();
                chk("hold_strobe", {mem_re, mem_we}, {!we, we});
                chk("hold_addr", mem_addr, addr);
                chk("hold_nodone", {cpu_done, uart_done}, 2'b00);
            end
            if (c == lat) begin
                mem_rdata = rv;
                mem_ready_we = we;
                mem_ready_re = !we;
            end else begin
                mem_rdata = DW'($urandom);
                mem_ready_we = 1'b0;
                mem_ready_re = 1'b0;
            end
            if (noise && we) mem_ready_re = 1'b1;
            if (noise && !we) mem_ready_we = 1'b1;
        end
        step();
        mem_ready_re = 1'b0;
        mem_ready_we = 1'b0;
        if (!we && side == 1'b0) cpu_rd_m = rv;
        if (!we && side == 1'b1) uart_rd_m = rv;
        chk("done_cpu", cpu_done, side == 1'b0);
        chk("done_uart", uart_done, side == 1'b1);
        chk("done_strobes", {mem_re, mem_we}, 2'b00);
        chk("cpu_rdata", cpu_rdata, cpu_rd_m);
        chk("uart_rdata", uart_rdata, uart_rd_m);
        chk("timeout_err", timeout_err, terr_m);
        if (side == 1'b0) begin
            cpu_re = 1'b0;
            cpu_we = 1'b0;
        end else begin
            uart_re = 1'b0;
            uart_we = 1'b0;
        end
        // stray readies during RECOVER must be ignored
        mem_ready_re = 1'b1;
        mem_ready_we = 1'b1;
        step();
        mem_ready_re = 1'b0;
        mem_ready_we = 1'b0;
        chk("recover_strobes", {mem_re, mem_we}, 2'b00);
        chk("recover_nodone", {cpu_done, uart_done}, 2'b00);
    endtask

    // Model-driven transaction: applies both requests and predicts grant order
    task automatic model_txn(input logic cp, input logic up, input int lat, input logic noise);
        logic          first, c_w, u_w, both;
        logic [AW-1:0] c_addr;
        cpu_re = cp & ($urandom_range(0, 1) == 1);
        cpu_we = cp & !cpu_re;
        if (cp && $urandom_range(0, 3) == 0) begin cpu_re = 1'b1; cpu_we = 1'b1; end
        uart_re = up & ($urandom_range(0, 1) == 1);
        uart_we = up & !uart_re;
        if (up && $urandom_range(0, 3) == 0) begin uart_re = 1'b1; uart_we = 1'b1; end
        cpu_addr_rd = AW'($urandom);
        cpu_addr_wr = AW'($urandom);
        cpu_wdata   = DW'($urandom);
        uart_addr   = AW'($urandom);
        uart_wdata  = DW'($urandom);
        c_w = cpu_we;
        u_w = uart_we;
        c_addr = c_w ? cpu_addr_wr : cpu_addr_rd;
        both = cp && up;
        if (both) begin
            first = ptr_m;
            ptr_m = ~ptr_m;
        end else begin
            first = up;
        end
        if (first == 1'b0) run_acc(1'b0, c_w, c_addr, cpu_wdata, lat, DW'($urandom), noise);
        else               run_acc(1'b1, u_w, uart_addr, uart_wdata, lat, DW'($urandom), noise);
        if (both && first == 1'b0) run_acc(1'b1, u_w, uart_addr, uart_wdata, lat, DW'($urandom), noise);
        if (both && first == 1'b1) run_acc(1'b0, c_w, c_addr, cpu_wdata, lat, DW'($urandom), noise);
    endtask

    initial begin
        vecs[0] = '{1, 0, 19'h00123, 19'h0, 8'h00, 0, 0, 19'h0, 8'h00, 4, 8'h5A, 0,
                    0, 0, 19'h00123, 8'h00, 0, 0, 0, 19'h0, 8'h00};
        vecs[1] = '{1, 1, 19'h00010, 19'h00020, 8'hC3, 0, 0, 19'h0, 8'h00, 2, 8'h00, 0,
                    0, 1, 19'h00020, 8'hC3, 0, 0, 0, 19'h0, 8'h00};
        vecs[2] = '{1, 0, 19'h00100, 19'h0, 8'h00, 0, 1, 19'h00200, 8'h11, 1, 8'h77, 0,
                    0, 0, 19'h00100, 8'h00, 1, 1, 1, 19'h00200, 8'h11};
        vecs[3] = '{0, 1, 19'h0, 19'h00300, 8'h22, 1, 0, 19'h00400, 8'h00, 2, 8'h88, 0,
                    1, 0, 19'h00400, 8'h00, 1, 0, 1, 19'h00300, 8'h22};
        vecs[4] = '{1, 0, 19'h00500, 19'h0, 8'h00, 1, 0, 19'h00600, 8'h00, 1, 8'h99, 0,
                    0, 0, 19'h00500, 8'h00, 1, 1, 0, 19'h00600, 8'h00};
        vecs[5] = '{1, 1, 19'h00001, 19'h00700, 8'h33, 1, 1, 19'h00701, 8'h44, 3, 8'h00, 0,
                    1, 1, 19'h00701, 8'h44, 1, 0, 1, 19'h00700, 8'h33};
        vecs[6] = '{0, 0, 19'h0, 19'h0, 8'h00, 0, 1, 19'h7FFFF, 8'hA5, 3, 8'h00, 1,
                    1, 1, 19'h7FFFF, 8'hA5, 0, 0, 0, 19'h0, 8'h00};

        rst = 1'b1;
        {cpu_re, cpu_we, uart_re, uart_we, mem_ready_re, mem_ready_we} = 6'b0;
        cpu_addr_rd = '0; cpu_addr_wr = '0; uart_addr = '0;
        cpu_wdata = '0; uart_wdata = '0; mem_rdata = '0;
        ptr_m = 1'b0; cpu_rd_m = '0; uart_rd_m = '0; terr_m = 1'b0;
        step();
        step();
        chk("reset_outputs", {mem_re, mem_we, cpu_done, uart_done, timeout_err}, 5'b0);
        chk("reset_rdata", {cpu_rdata, uart_rdata}, 16'h0);
        chk("reset_bus", {mem_addr, mem_wdata}, 27'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            cpu_re = vecs[i].c_re; cpu_we = vecs[i].c_we;
            cpu_addr_rd = vecs[i].c_ard; cpu_addr_wr = vecs[i].c_awr; cpu_wdata = vecs[i].c_wd;
            uart_re = vecs[i].u_re; uart_we = vecs[i].u_we;
            uart_addr = vecs[i].u_a; uart_wdata = vecs[i].u_wd;
            if ((vecs[i].c_re | vecs[i].c_we) && (vecs[i].u_re | vecs[i].u_we)) ptr_m = ~ptr_m;
            run_acc(vecs[i].e1_side, vecs[i].e1_we, vecs[i].e1_addr, vecs[i].e1_wd,
                    vecs[i].lat, vecs[i].rv, vecs[i].noise);
            if (vecs[i].e2_v)
                run_acc(vecs[i].e2_side, vecs[i].e2_we, vecs[i].e2_addr, vecs[i].e2_wd,
                        vecs[i].lat, ~vecs[i].rv, vecs[i].noise);
        end

        // Timeout on a CPU read: strobe held TO cycles, done, rdata kept, sticky error
        cpu_re = 1'b1;
        cpu_addr_rd = 19'h0ABCD;
        mem_rdata = 8'hEE;
        for (int c = 1; c <= TO; c++) begin
            step();
            chk("to_strobe", mem_re, 1'b1);
            chk("to_nodone", cpu_done, 1'b0);
        end
        step();
        terr_m = 1'b1;
        chk("to_drop", {mem_re, mem_we}, 2'b00);
        chk("to_done", cpu_done, 1'b1);
        chk("to_rdata_kept", cpu_rdata, cpu_rd_m);
        chk("to_err", timeout_err, 1'b1);
        cpu_re = 1'b0;
        step();
        chk("to_err_recover", timeout_err, 1'b1);

        // Randomized traffic with idle gaps and stray readies in IDLE
        for (int t = 0; t < 40; t++) begin
            int sel = $urandom_range(1, 3);
            model_txn(sel[0], sel[1], $urandom_range(1, TO - 2), ($urandom_range(0, 1) == 1));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                mem_ready_re = ($urandom_range(0, 1) == 1);
                mem_ready_we = ($urandom_range(0, 1) == 1);
                step();
                chk("idle_quiet", {mem_re, mem_we, cpu_done, uart_done}, 4'b0);
            end
            mem_ready_re = 1'b0;
            mem_ready_we = 1'b0;
        end

        // Reset in the middle of an access
        uart_re = 1'b1;
        uart_addr = 19'h12345;
        step();
        chk("rst_pre_strobe", mem_re, 1'b1);
        step();
        rst = 1'b1;
        mem_ready_re = 1'b1;
        step();
        chk("rst_strobes", {mem_re, mem_we}, 2'b00);
        chk("rst_nodone", {cpu_done, uart_done}, 2'b00);
        chk("rst_err", timeout_err, 1'b0);
        chk("rst_rdata", {cpu_rdata, uart_rdata}, 16'h0);
        rst = 1'b0;
        mem_ready_re = 1'b0;
        uart_re = 1'b0;
        ptr_m = 1'b0; cpu_rd_m = '0; uart_rd_m = '0; terr_m = 1'b0;
        step();
        chk("rst_idle", {mem_re, mem_we}, 2'b00);
        model_txn(1'b1, 1'b1, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
